// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states and bus field widths.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  localparam logic [ADDR_W-1:0] GEN_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into the clk domain and derives scl edge strobes plus START/STOP.
// Strobes are combinational from the synced and history stages, so logic acting on them reacts 3 clk after a pin change.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synchronized level, [2] history for edge detection
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  // Reset to the idle-bus level so releasing reset on a quiet bus creates no edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every stage samples the pre-edge value.
      scl_sh <= {scl_sh[1:0], scl};
      sda_sh <= {sda_sh[1:0], sda};
    end
  end

  assign sda_level = sda_sh[1];
  assign scl_rise  =  scl_sh[1] & ~scl_sh[2];
  assign scl_fall  = ~scl_sh[1] &  scl_sh[2];
  assign start_det =  sda_sh[2] & ~sda_sh[1] & scl_sh[1] & scl_sh[2];
  assign stop_det  = ~sda_sh[2] &  sda_sh[1] & scl_sh[1] & scl_sh[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address: receives write bytes, serves read bytes, never stretches scl.
// Optional general-call (address byte 8'h00) support is enabled with `define GENERAL_CALL_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h42
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_req,
  output logic              rw,
  output logic              busy,
  output logic              gen_call
);

  logic              sda_level;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  state_t            state;
  logic [BYTE_W-1:0] shifter;
  logic [3:0]        bit_cnt;
  logic              sda_low;
  logic [BYTE_W-1:0] addr_byte;
  logic              addr_hit;
  logic              gc_hit;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda       (sda),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open drain: only ever pull low or let go.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // The byte as it will look once the bit being sampled now is shifted in.
  assign addr_byte = {shifter[BYTE_W-2:0], sda_level};
  assign addr_hit  = (addr_byte[BYTE_W-1:1] == SLAVE_ADDR);
`ifdef GENERAL_CALL_EN
  assign gc_hit = (addr_byte == {GEN_CALL_ADDR, 1'b0});
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      sda_low  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      gen_call <= 1'b0;
    end else begin
      // NOTE: pulses default low every clk and are overridden below only in the clk they fire.
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_low  <= 1'b0;
        gen_call <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sda_low  <= 1'b0;
        gen_call <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shifter <= addr_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (addr_hit || gc_hit) begin
                  rw       <= addr_byte[0];
                  gen_call <= gc_hit;
                  state    <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= WAIT_STOP;
                end
              end
            end
          end
          // sda_low doubles as the phase marker: clear on entry, set once the ACK is on the bus.
          ADDR_ACK: begin
            if (scl_rise && sda_low && rw) begin
              tx_req <= 1'b1;
            end
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
                busy    <= 1'b1;
              end else if (rw) begin
                shifter <= tx_data;
                sda_low <= ~tx_data[BYTE_W-1];
                bit_cnt <= '0;
                state   <= RD_DATA;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shifter <= addr_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              rx_data  <= shifter;
              rx_valid <= 1'b1;
              sda_low  <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                state   <= RD_ACK;
              end else begin
                shifter <= {shifter[BYTE_W-2:0], 1'b0};
                sda_low <= ~shifter[BYTE_W-2];
              end
            end
          end
          // bit_cnt 8 = waiting for the master's ACK bit, 9 = ACK seen, next byte due.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_level) begin
                state <= WAIT_STOP;
              end else begin
                tx_req  <= 1'b1;
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              shifter <= tx_data;
              sda_low <= ~tx_data[BYTE_W-1];
              bit_cnt <= '0;
              state   <= RD_DATA;
            end
          end
          IDLE, WAIT_STOP: begin
            sda_low <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on an open-drain bus with a pull-up.
// Expected values are hand-computed; pulse counters observe rx_valid, tx_req and target-driven lows.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 4;    // quarter scl period in clk cycles
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       rw;
  logic       busy;
  logic       gen_call;
  wire        sda;

  int checks = 0;
  int errors = 0;
  int rx_valid_cnt = 0;
  int tx_req_cnt = 0;
  int slave_low_cnt = 0;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy),
    .gen_call (gen_call)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_valid_cnt++;
    if (tx_req === 1'b1) tx_req_cnt++;
    if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic seen);
    m_sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    seen = sda;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  // Ends at the instant sda is released with scl high.
  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if ({rx_valid, tx_req, rw, busy, gen_call} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {rx_valid, tx_req, rw, busy, gen_call}); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda); end
    reset_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_write();
    logic ack;
    int rv0;
    rv0 = rx_valid_cnt;
    bus_start();
    write_byte(8'h84, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack got=%b exp=0", ack); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rx_data got=%h exp=a5", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("FAIL wr_rx_valid_cycles got=%0d exp=1", rx_valid_cnt - rv0); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL wr_rw got=%b exp=0", rw); end
    bus_stop();
    wait_clk(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_before_stop_det got=%b exp=1", busy); end
    wait_clk(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    wait_clk(HALF);
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int tr0;
    tr0 = tx_req_cnt;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h85, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rd_rw got=%b exp=1", rw); end
    tx_data = 8'hC3;
    read_byte(1'b0, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_byte1 got=%h exp=3c", d); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte2 got=%h exp=c3", d); end
    checks++; if (tx_req_cnt - tr0 !== 2) begin errors++; $display("FAIL rd_tx_req_cycles got=%0d exp=2", tx_req_cnt - tr0); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rd_sda_after_nack got=%b exp=1", sda); end
    checks++; if (dut.state !== WAIT_STOP) begin errors++; $display("FAIL rd_state_after_nack got=%0d exp=%0d", dut.state, WAIT_STOP); end
    bus_stop();
    wait_clk(HALF);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rd_state_after_stop got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int rv0, sl0;
    rv0 = rx_valid_cnt;
    sl0 = slave_low_cnt;
    bus_start();
    write_byte(8'h90, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_ack got=%b exp=1", ack); end
    write_byte(8'hFF, ack);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got=%b exp=0", busy); end
    bus_stop();
    wait_clk(HALF);
    checks++; if (slave_low_cnt - sl0 !== 0) begin errors++; $display("FAIL mm_sda_driven got=%0d exp=0", slave_low_cnt - sl0); end
    checks++; if (rx_valid_cnt - rv0 !== 0) begin errors++; $display("FAIL mm_rx_valid got=%0d exp=0", rx_valid_cnt - rv0); end
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_data got=%h exp=11", rx_data); end
    bus_rstart();
    tx_data = 8'h5A;
    write_byte(8'h85, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%b exp=1", busy); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rs_read got=%h exp=5a", d); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rs_rw got=%b exp=1", rw); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_hold got=%h exp=11", rx_data); end
    bus_stop();
    wait_clk(HALF);
  endtask

  task automatic test_abort();
    logic ack, s;
    int rv0;
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2);
    reset_n = 1'b0;
    wait_clk(2);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL ab_sda_in_reset got=%b exp=1", sda); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ab_rx_data got=%h exp=00", rx_data); end
    checks++; if ({rw, busy, gen_call, tx_req, rx_valid} !== 5'b0) begin errors++; $display("FAIL ab_flags got=%b exp=00000", {rw, busy, gen_call, tx_req, rx_valid}); end
    reset_n = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
    bus_stop();
    wait_clk(HALF);
    rv0 = rx_valid_cnt;
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h77, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ab_data_ack got=%b exp=0", ack); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL ab_rx_data_new got=%h exp=77", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("FAIL ab_rx_valid got=%0d exp=1", rx_valid_cnt - rv0); end
    bus_stop();
    wait_clk(HALF);
  endtask

  task automatic test_general_call();
    logic ack_a, ack_d;
    int rv0;
    rv0 = rx_valid_cnt;
    bus_start();
    write_byte(8'h00, ack_a);
    write_byte(8'h06, ack_d);
`ifdef GENERAL_CALL_EN
    checks++; if ({ack_a, ack_d} !== 2'b00) begin errors++; $display("FAIL gc_acks got=%b exp=00", {ack_a, ack_d}); end
    checks++; if (gen_call !== 1'b1) begin errors++; $display("FAIL gc_flag got=%b exp=1", gen_call); end
    checks++; if (rx_data !== 8'h06) begin errors++; $display("FAIL gc_rx_data got=%h exp=06", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("FAIL gc_rx_valid got=%0d exp=1", rx_valid_cnt - rv0); end
`else
    checks++; if ({ack_a, ack_d} !== 2'b11) begin errors++; $display("FAIL gc_acks got=%b exp=11", {ack_a, ack_d}); end
    checks++; if (gen_call !== 1'b0) begin errors++; $display("FAIL gc_flag got=%b exp=0", gen_call); end
    checks++; if (rx_valid_cnt - rv0 !== 0) begin errors++; $display("FAIL gc_rx_valid got=%0d exp=0", rx_valid_cnt - rv0); end
`endif
    bus_stop();
    wait_clk(HALF);
    checks++; if (gen_call !== 1'b0) begin errors++; $display("FAIL gc_after_stop got=%b exp=0", gen_call); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_back_to_back();
    test_abort();
    test_general_call();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) that pairs with the team's I2C master on the same open-drain scl/sda bus.
- Oversamples scl/sda on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it. Receives write bytes into a one-byte output register, and serves read bytes from a user-supplied input.
- Never drives scl; no clock stretching.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this target responds to.

Ports:
- clk  input  1  system clock; scl half-period must be at least 4 clk cycles.
- reset_n  input  1  reset, asynchronous and active-low.
- scl  input  1  bus clock from the master.
- sda  inout  1  open-drain data line; the block drives only 0 or z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to return on a read.
- tx_req  output  1  one-clk pulse requesting the next tx_data.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high from an addressed START until STOP.
- gen_call  output  1  high while in a general-call transaction (see Optional Feature).

Behaviour:
- **Reset (async, reset_n=0):** sda released (z); rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, gen_call=0; state IDLE; shift register and bit counter cleared.
- **Input conditioning:** scl and sda each pass through a 2-FF synchronizer plus one history FF.
  - scl_rise/scl_fall are single-clk strobes.
  - START = synced sda falls while synced scl is high.
  - STOP = synced sda rises while synced scl is high.
  - Detection latency is 3 clk.
- **Sampling and driving:** data is sampled on scl_rise. sda drive changes only on scl_fall.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **IDLE:** START -> ADDR, with bit counter = 0.
- **ADDR:** shift 8 bits MSB first on scl_rise. After the 8th bit:
  - if bits[7:1]==SLAVE_ADDR: rw=bits[0], go to ADDR_ACK;
  - otherwise go to WAIT_STOP (never drive sda).
- **ADDR_ACK:**
  - On the scl_fall ending the 8th bit: drive sda=0 and set busy=1.
  - If rw=1: pulse tx_req on the scl_rise of the ACK bit.
  - On the next scl_fall:
    - rw=0: release sda, go to WR_DATA.
    - rw=1: latch tx_data into the shifter, drive its MSB, go to RD_DATA.
- **WR_DATA:** shift 8 bits on scl_rise. On the scl_fall after the 8th bit:
  - rx_data <= shifter, rx_valid pulses for 1 clk;
  - drive sda=0, go to WR_ACK.
- **WR_ACK:** on scl_fall, release sda and go to WR_DATA. Every written byte is ACKed.
- **RD_DATA:**
  - Present bit 7 down to bit 0; each bit is driven from the scl_fall before its scl_rise. A 1 bit means z.
  - After bit 0's scl_fall, release sda and go to RD_ACK.
- **RD_ACK:** sample sda on scl_rise.
  - 0 (master ACK): pulse tx_req in the same clk as the sample. On the next scl_fall, latch tx_data, drive its MSB, go to RD_DATA.
  - 1 (master NACK): go to WAIT_STOP with sda released.
- **WAIT_STOP:** ignore all bits, sda released.
- **Global transitions (all states):**
  - STOP -> IDLE, busy=0, sda released.
  - START (repeated START) -> ADDR; busy stays 1 until the address phase resolves, then follows the match.
  - A START seen in the same clk as a STOP cannot occur; START has priority.
- **Hold/retain rules:** rx_data holds its value until the next completed byte. An incomplete byte aborted by START or STOP never updates rx_data or pulses rx_valid.
- **Reset mid-transfer:** sda released within the reset assertion; the block re-synchronizes at the next START.

Optional Feature:
- Macro GENERAL_CALL_EN.
- **Defined:** address byte 8'h00 (address 0, rw=0) is ACKed. The block proceeds as a write with gen_call=1 until STOP or START; address 0 with rw=1 goes to WAIT_STOP.
- **Undefined:** 8'h00 is treated as a mismatch and gen_call is tied to 0.

Decomposition:
- Shared package i2c_pkg:
  - state encoding constants: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP;
  - ADDR_W=7 and BYTE_W=8;
  - GEN_CALL_ADDR=7'h00.
- One sub-module i2c_bus_sync: synchronizers, edge strobes, START/STOP detect.

Test Plan:
- **Write match:** SLAVE_ADDR=7'h42, master writes address 0x84 then data 0xA5 -> ACK low in both 9th slots; rx_valid one pulse; rx_data=0xA5; rw=0; busy falls 3 clk after STOP.
- **Read:** master reads address 0x85, tx_data=0x3C then 0xC3, master ACKs byte 1 and NACKs byte 2 -> sda shows 0x3C then 0xC3 MSB first; tx_req pulses twice; sda released after the NACK; state WAIT_STOP then IDLE.
- **Address mismatch:** master sends 0x90 + data 0xFF -> sda never driven low; no rx_valid; busy stays 0.
- **Repeated START:** write 0x84, data 0x11, repeated START, read 0x85 with tx_data=0x5A -> rx_data=0x11, then 0x5A read back, rw=1.
- **Abort:** reset_n pulsed low during bit 4 of a write byte, then a fresh write of 0x77 -> sda z during reset; all outputs at reset values; 0x77 received and rx_valid pulses once.
- **GENERAL_CALL_EN:** defined, address byte 0x00 + data 0x06 -> ACKed, gen_call=1, rx_data=0x06. Undefined, same stimulus -> NACK, no rx_valid.
